// File: rtl/regfile_param.sv
// Parametrised register file: one synchronous write port, two combinational read
// ports, optional hardwired-zero entry 0, optional write bypass and a bulk-clear engine.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  // state   | meaning
  // S_IDLE  | normal operation, writes accepted
  // S_CLEAR | zeroing entry[cnt] each edge, writes dropped
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DEPTH-1:0]  wdec;

  always_comb begin
    wdec = '0;
    if (we && !busy_q) wdec[waddr] = 1'b1;
    if (ZERO_REG != 0) wdec[0] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    wr_drop_d = we && busy_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  // A write accepted on the clr_req edge lands first and is zeroed later by the sweep.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = wdec[i] ? wdata : mem_q[i];
    end
    if (state_q == S_CLEAR) mem_d[cnt_q] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // wdec already folds in we, busy and the zero-entry rule, so it doubles as the bypass match.
  always_comb begin
    rdata1 = mem_q[raddr1];
    if (BYPASS != 0 && wdec[raddr1]) rdata1 = wdata;
    if (ZERO_REG != 0 && raddr1 == '0) rdata1 = '0;
  end

  always_comb begin
    rdata2 = mem_q[raddr2];
    if (BYPASS != 0 && wdec[raddr2]) rdata2 = wdata;
    if (ZERO_REG != 0 && raddr2 == '0) rdata2 = '0;
  end

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param; a second instance with BYPASS=0
// shares the stimulus to compare forwarding against plain array reads.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic        clr_req = 1'b0;
  logic [31:0] rdata1, rdata2, rdata1_nb, rdata2_nb;
  logic        busy, wr_drop, busy_nb, wr_drop_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
  );

  regfile_param #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_nb), .rdata2(rdata2_nb),
    .clr_req(clr_req), .busy(busy_nb), .wr_drop(wr_drop_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    tick();
    tick();
    raddr1 = 5'd5;
    raddr2 = 5'd31;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++;
    if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop got %0b exp 0", wr_drop); end
    checks++;
    if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp 0", rdata1); end
    checks++;
    if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata2 got %h exp 0", rdata2); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd6;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rd1 got %h exp deadbeef", rdata1); end
    checks++;
    if (rdata2 !== 32'h0) begin errors++; $display("FAIL write_rd2 got %h exp 0", rdata2); end
    checks++;
    if (rdata1_nb !== 32'hDEADBEEF) begin errors++; $display("FAIL write_nb_rd1 got %h exp deadbeef", rdata1_nb); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin errors++; $display("FAIL zero_same_cycle got %h exp 0", rdata1); end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin errors++; $display("FAIL zero_next_cycle got %h exp 0", rdata1); end
    checks++;
    if (wr_drop !== 1'b0) begin errors++; $display("FAIL zero_wr_drop got %0b exp 0", wr_drop); end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h11110000;
    tick();
    wdata = 32'hA5A5A5A5; raddr2 = 5'd7;
    #1;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_same got %h exp a5a5a5a5", rdata2); end
    checks++;
    if (rdata2_nb !== 32'h11110000) begin errors++; $display("FAIL nobypass_old got %h exp 11110000", rdata2_nb); end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_next got %h exp a5a5a5a5", rdata2); end
    checks++;
    if (rdata2_nb !== 32'hA5A5A5A5) begin errors++; $display("FAIL nobypass_next got %h exp a5a5a5a5", rdata2_nb); end
  endtask

  task automatic test_clear();
    int n;
    for (int a = 0; a < 32; a++) begin
      we = 1'b1; waddr = 5'(a); wdata = 32'(a + 1);
      tick();
    end
    we = 1'b0;
    raddr1 = 5'd31;
    #1;
    checks++;
    if (rdata1 !== 32'd32) begin errors++; $display("FAIL fill_31 got %h exp 20", rdata1); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 5) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF; raddr2 = 5'd3;
        #1;
        checks++;
        if (rdata2 !== 32'h0) begin errors++; $display("FAIL busy_no_bypass got %h exp 0", rdata2); end
      end
      if (n == 6) begin
        we = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %0b exp 1", wr_drop); end
      end
      if (n == 7) begin
        checks++;
        if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_end got %0b exp 0", wr_drop); end
      end
      if (n == 16) begin
        raddr1 = 5'd31;
        #1;
        checks++;
        if (rdata1 !== 32'd32) begin errors++; $display("FAIL mid_clear_31 got %h exp 20", rdata1); end
      end
      if (n == 31) begin
        we = 1'b1; waddr = 5'd9; wdata = 32'h99999999;
      end
      n++;
      tick();
    end
    we = 1'b0;
    checks++;
    if (n !== 32) begin errors++; $display("FAIL busy_cycles got %0d exp 32", n); end
    checks++;
    if (wr_drop !== 1'b1) begin errors++; $display("FAIL final_edge_drop got %0b exp 1", wr_drop); end
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(a);
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2_nb !== 32'h0) begin
        errors++; $display("FAIL cleared_%0d got %h/%h exp 0", a, rdata1, rdata2_nb);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    we = 1'b1; waddr = 5'd31; wdata = 32'h31313131; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0; raddr1 = 5'd31;
    #1;
    checks++;
    if (wr_drop !== 1'b0) begin errors++; $display("FAIL clr_write_drop got %0b exp 0", wr_drop); end
    checks++;
    if (rdata1 !== 32'h31313131) begin errors++; $display("FAIL clr_write_commit got %h exp 31313131", rdata1); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy got %0b exp 1", busy); end
    repeat (9) tick();
    we = 1'b1; waddr = 5'd4; wdata = 32'h44444444;
    tick();
    we = 1'b0;
    checks++;
    if (wr_drop !== 1'b1) begin errors++; $display("FAIL pre_rst_drop got %0b exp 1", wr_drop); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %0b exp 0", busy); end
    checks++;
    if (wr_drop !== 1'b0) begin errors++; $display("FAIL async_rst_drop got %0b exp 0", wr_drop); end
    checks++;
    if (rdata1 !== 32'h0) begin errors++; $display("FAIL async_rst_31 got %h exp 0", rdata1); end
    #2 rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %0b exp 0", busy); end
    we = 1'b1; waddr = 5'd2; wdata = 32'hCAFE0002;
    tick();
    we = 1'b0; raddr1 = 5'd2;
    #1;
    checks++;
    if (rdata1 !== 32'hCAFE0002) begin errors++; $display("FAIL post_rst_write got %h exp cafe0002", rdata1); end
    checks++;
    if (wr_drop !== 1'b0) begin errors++; $display("FAIL post_rst_drop got %0b exp 0", wr_drop); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file that supersedes the fixed 32-entry write-enable decoder with a complete storage block. It holds 2**ADDR_W words of DATA_W bits and offers one synchronous write port through an internal one-hot write decoder and two asynchronous read ports. It also provides an optional hardwired-zero entry 0, optional write-to-read bypass, and a sequential bulk-clear engine with a busy flag. It sits in the CPU datapath between the decode stage (read addresses) and the writeback stage (write port).

## Interface
- DATA_W, 32, width of each register in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- raddr1  input  ADDR_W  read port 1 address
- raddr2  input  ADDR_W  read port 2 address
- rdata1  output  DATA_W  read port 1 data, combinational
- rdata2  output  DATA_W  read port 2 data, combinational
- clr_req  input  1  request bulk clear of all entries
- busy  output  1  registered; high while the clear engine runs
- wr_drop  output  1  registered one-cycle pulse; a write was rejected because busy was high

## Operation
- Write decoder: one-hot vector of DEPTH bits.
  - Bit waddr is set only when we=1 and busy=0.
  - All bits are 0 otherwise.
  - With ZERO_REG=1, bit 0 is forced to 0.
- Write: on a rising edge, the entry selected by the decoder takes wdata.
- Read: rdataN = entry[raddrN], with two overrides:
  - ZERO_REG=1 and raddrN=0: rdataN = 0.
  - BYPASS=1, we=1, busy=0, waddr=raddrN and the zero rule does not apply: rdataN = wdata.
- Clear FSM has two states, IDLE and CLEAR, plus an ADDR_W-bit counter cnt.
  - IDLE -> CLEAR: on an edge with clr_req=1. Sets cnt=0 and busy=1.
  - CLEAR: each edge writes 0 to entry[cnt] and increments cnt.
  - CLEAR -> IDLE: on the edge where cnt = DEPTH-1. That edge clears the last entry and sets busy=0. cnt wraps to 0.
  - clr_req is ignored while in CLEAR; there is no queuing and no restart.
- Writes during CLEAR are discarded. wr_drop=1 in the cycle after each edge where we=1 and busy=1; otherwise wr_drop=0.
- A write to entry 0 with ZERO_REG=1 is silently discarded and does not set wr_drop.
- Reads during CLEAR return current contents, so entries not yet cleared keep their old values. Bypass is disabled while busy=1.
- Reset (asynchronous): all entries = 0, state = IDLE, cnt = 0, busy = 0, wr_drop = 0.
  - Reset mid-clear aborts the clear immediately. Since every entry is zeroed anyway, there is no partial state.

## Timing
- Write latency: the value is stored at the edge and visible through the array in the following cycle. With BYPASS=1 it is also visible in the same cycle.
- Read latency: 0 cycles (combinational from raddrN).
- Bulk clear: busy rises after the edge that samples clr_req and stays high for exactly DEPTH cycles (32 with defaults). The first read guaranteed to see all-zero data is in the cycle after busy falls.
- Simultaneous we=1 and clr_req=1 in IDLE: the write commits at that edge and is then cleared by the engine. No wr_drop.
- Simultaneous we=1 and the final CLEAR edge: the write is dropped because busy=1 was sampled, and wr_drop pulses.
- Same-address read and write, BYPASS=0: old data this cycle, new data next cycle.

## Test plan
- Reset, then write 0xDEADBEEF to addr 5, then read raddr1=5 the next cycle -> rdata1=0xDEADBEEF. raddr2=6 -> rdata2=0.
- ZERO_REG=1: write 0x12345678 to addr 0 -> rdata1 with raddr1=0 reads 0 in the same and the next cycle, and wr_drop stays 0.
- BYPASS=1: we=1, waddr=raddr2=7, wdata=0xA5A5A5A5 -> rdata2=0xA5A5A5A5 in the same cycle. Repeat with BYPASS=0 -> rdata2 shows the old value, then 0xA5A5A5A5 next cycle.
- Fill all 32 entries with value addr+1, pulse clr_req -> busy high for exactly 32 cycles. Mid-clear, addr 31 still reads 32. After busy falls, every address reads 0.
- During CLEAR, we=1 to addr 3 with 0xFFFF_FFFF -> wr_drop=1 the next cycle, and addr 3 reads 0 after the clear completes.
- Assert rst asynchronously at cycle 10 of a clear, between clock edges -> busy and wr_drop go to 0 immediately. After release, clr_req=0 keeps the block IDLE, and a write to addr 2 succeeds on the first edge.
